// File: rtl/multicycle_control_if.sv
// Bus between the multicycle controller and the datapath/memory side.
//   master : the controller. It takes opcode and mem_ready and drives every
//            control strobe plus the state, retire, instr_count and fault
//            status outputs.
//   slave  : the datapath/memory. It drives opcode and mem_ready and takes
//            the control strobes.
interface multicycle_control_if;
  logic [5:0]  opcode;         // IR[31:26], valid from DECODE onward
  logic        mem_ready;      // memory access completes this cycle
  logic        pc_write;       // unconditional PC load
  logic        pc_write_cond;  // PC load if ALU zero
  logic        i_or_d;         // memory address: 0 PC, 1 ALUOut
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        mem_to_reg;     // register write data: 0 ALUOut, 1 MDR
  logic        reg_dst;        // destination register: 0 rt, 1 rd
  logic        reg_write;
  logic        alu_src_a;      // 0 PC, 1 A
  logic [1:0]  alu_src_b;      // 00 B, 01 4, 10 imm, 11 imm<<2
  logic [1:0]  alu_op;         // 00 add, 01 sub, 10 funct
  logic [1:0]  pc_source;      // 00 ALU, 01 ALUOut, 10 jump target
  logic [3:0]  state;
  logic        retire;
  logic [15:0] instr_count;
  logic        fault;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, retire, instr_count, fault
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, retire, instr_count, fault
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM. It supports lw, sw, R-type, beq, j and
// addi. Memory accesses (FETCH, MEMRD, MEMWR) wait for mem_ready. Each access
// may wait at most MEM_TIMEOUT cycles with mem_ready low. When that limit is
// reached the FSM enters FAULT, where it drives every control low and sets
// fault. It stays in FAULT until reset.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; all controls read 0 while it is low
//   bus   : multicycle_control_if.master (opcode/mem_ready in; control,
//           state, retire, instr_count and fault out)
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_FAULT  = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       retire;
  } ctrl_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // The counter must be able to hold MEM_TIMEOUT-1.
  localparam int            CW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q;
  logic [15:0]   count_q;
  ctrl_t         ctrl;
  ctrl_t         ctrl_out;
  logic          access;
  logic          timeout;

  assign access  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout = access && !bus.mem_ready && (wait_q == WAIT_LAST);

  // NOTE: every signal gets its default before the case statement. A branch
  // that leaves a signal unassigned would otherwise infer a latch. These
  // defaults also give the all-zero values for unlisted controls.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (bus.mem_ready)  state_d = S_MEMWB;
        else if (timeout)   state_d = S_FAULT;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          ctrl.retire = 1'b1;
          state_d     = S_FETCH;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        state_d        = S_RWB;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        ctrl.retire        = 1'b1;
        state_d            = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
        ctrl.retire    = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
        state_d        = S_FETCH;
      end
      S_FAULT:  state_d = S_FAULT;
      // Unused codes 12-14 trap with all controls low.
      default:  state_d = S_FAULT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples pre-edge values, so the order of the blocks does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (!access || bus.mem_ready || (state_d != state_q)) wait_q <= '0;
      else                                                  wait_q <= wait_q + CW'(1);
      if (ctrl.retire) count_q <= count_q + 16'd1;
    end
  end

  // NOTE: the flops already reset to FETCH, but FETCH drives mem_read. The
  // controls are therefore also gated combinationally with rst_n. This holds
  // them low for the whole time reset is asserted, not only from the next
  // clock edge.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.i_or_d        = ctrl_out.i_or_d;
  assign bus.mem_read      = ctrl_out.mem_read;
  assign bus.mem_write     = ctrl_out.mem_write;
  assign bus.ir_write      = ctrl_out.ir_write;
  assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
  assign bus.reg_dst       = ctrl_out.reg_dst;
  assign bus.reg_write     = ctrl_out.reg_write;
  assign bus.alu_src_a     = ctrl_out.alu_src_a;
  assign bus.alu_src_b     = ctrl_out.alu_src_b;
  assign bus.alu_op        = ctrl_out.alu_op;
  assign bus.pc_source     = ctrl_out.pc_source;
  assign bus.retire        = ctrl_out.retire;
  assign bus.state         = state_q;
  assign bus.instr_count   = count_q;
  // FAULT is only left through reset, so this flag stays set once raised.
  assign bus.fault         = (state_q == S_FAULT);

endmodule
